melody_sequencer: RTL and testbench



---
 rtl/melody_pkg.sv | 24 ++
 rtl/melody_sequencer_if.sv | 10 +
 rtl/melody_sequencer_beat_timer.sv | 28 ++
 rtl/melody_sequencer.sv | 143 ++++++++++++++
 tb/tb_melody_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/melody_pkg.sv
// Shared types and ROM word layout for the melody sequencer.
package melody_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PLAY,
        DONE
    } state_t;

    localparam int DUR_MSB = 39;
    localparam int DUR_LSB = 32;
    localparam int PER_MSB = 31;
    localparam int PER_LSB = 0;

    localparam logic [7:0]  END_MARKER  = 8'd0;
    localparam logic [31:0] REST_PERIOD = 32'd0;

    function automatic logic is_rest(input logic [31:0] period);
        return period == REST_PERIOD;
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// ROM read bus between the sequencer (master) and the song ROM (slave).
interface melody_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [39:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/melody_sequencer_beat_timer.sv
// Beat counter: counts 0..BEAT_CYCLES-1 while enabled, pulses beat_tick on wrap.
module beat_timer #(
    parameter int BEAT_CYCLES = 12500000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           clr,
    output logic [$clog2(BEAT_CYCLES)-1:0] beat_cnt,
    output logic                           beat_tick
);
    localparam int              CNT_W = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_CYCLES - 1);

    assign beat_tick = en && !clr && (beat_cnt == LAST);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
        end else if (en) begin
            beat_cnt <= beat_tick ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a song ROM and drives wave_generator period/en.
// Define MELODY_SEQ_GAP_EN to silence the tail of every note for articulation.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    melody_sequencer_if.master    rom,
    output logic                  wave_en,
    output logic [31:0]           wave_period,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     note_idx
);
    localparam int CNT_W = $clog2(BEAT_CYCLES);
`ifdef MELODY_SEQ_GAP_EN
    localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_CYCLES - GAP_CYCLES);
`endif

    state_t            state, next_state;
    logic [7:0]        dur_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              en_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              beat_tick;
    logic              timer_en;
    logic              timer_clr;
    logic [7:0]        rom_dur;
    logic [31:0]       rom_per;
    logic              last_addr;
    logic              note_done;
    logic              gap_hit;

    assign rom.rom_addr = addr_q;
    assign rom_dur      = rom.rom_data[DUR_MSB:DUR_LSB];
    assign rom_per      = rom.rom_data[PER_MSB:PER_LSB];
    assign last_addr    = (addr_q == {ADDR_W{1'b1}});
    assign note_done    = beat_tick && (dur_cnt == 8'd0);
    assign timer_en     = (state == PLAY) && !pause;
    assign timer_clr    = (state != PLAY) || stop;

    beat_timer #(
        .BEAT_CYCLES(BEAT_CYCLES)
    ) u_beat_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (timer_en),
        .clr      (timer_clr),
        .beat_cnt (beat_cnt),
        .beat_tick(beat_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: assign a default first so no path through the block infers a latch.
    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = FETCH;
                FETCH:   next_state = LATCH;
                LATCH:   next_state = (rom_dur == END_MARKER) ? DONE : PLAY;
                PLAY:    if (note_done) next_state = last_addr ? DONE : FETCH;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Registered datapath: address, note latch and remaining-beat count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            note_idx    <= '0;
            dur_cnt     <= '0;
            en_q        <= 1'b0;
            wave_period <= '0;
        end else if (stop) begin
            addr_q      <= '0;
            en_q        <= 1'b0;
            wave_period <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) addr_q <= '0;
                end
                LATCH: begin
                    if (rom_dur != END_MARKER) begin
                        wave_period <= rom_per;
                        en_q        <= !is_rest(rom_per);
                        note_idx    <= addr_q;
                        dur_cnt     <= rom_dur - 8'd1;
                    end
                end
                PLAY: begin
                    if (beat_tick) begin
                        if (dur_cnt == 8'd0) begin
                            // The final address ends the song instead of wrapping to 0.
                            if (!last_addr) addr_q <= addr_q + 1'b1;
                        end else begin
                            dur_cnt <= dur_cnt - 8'd1;
                        end
                    end
                end
                DONE: begin
                    en_q        <= 1'b0;
                    wave_period <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        gap_hit = 1'b0;
`ifdef MELODY_SEQ_GAP_EN
        if (state inside {FETCH, LATCH, DONE}) begin
            gap_hit = 1'b1;
        end else if ((state == PLAY) && (dur_cnt == 8'd0) && (beat_cnt >= GAP_START)) begin
            gap_hit = 1'b1;
        end
`endif
        wave_en = en_q && !((state == PLAY) && pause) && !gap_hit;
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a per-cycle output timeline is derived from the song rules.
module tb_melody_sequencer;

    localparam int ADDR_W = 3;
    localparam int BC     = 4;
    localparam int GC     = 1;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MELODY_SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              pause;
    logic              wave_en;
    logic [31:0]       wave_period;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;

    melody_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    melody_sequencer #(
        .ADDR_W     (ADDR_W),
        .BEAT_CYCLES(BC),
        .GAP_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .rom        (bus),
        .wave_en    (wave_en),
        .wave_period(wave_period),
        .busy       (busy),
        .done       (done),
        .note_idx   (note_idx)
    );

    always #5 clk = ~clk;

    logic [39:0] rom_mem [DEPTH];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    // One expected observation per clock, plus the inputs driven in that cycle.
    typedef struct {
        logic              en;
        logic [31:0]       per;
        logic              busy;
        logic              done;
        logic [ADDR_W-1:0] idx;
        bit                chk_idx;
        logic [ADDR_W-1:0] addr;
        bit                is_play;
        bit                p;
        bit                sb;
        bit                sp;
    } ent_t;

    ent_t tl[$];
    ent_t exp_q[$];
    ent_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("wave_en@%0d", cyc), 32'(wave_en), 32'(mon_e.en));
            check($sformatf("wave_period@%0d", cyc), wave_period, mon_e.per);
            check($sformatf("busy@%0d", cyc), 32'(busy), 32'(mon_e.busy));
            check($sformatf("done@%0d", cyc), 32'(done), 32'(mon_e.done));
            check($sformatf("rom_addr@%0d", cyc), 32'(bus.rom_addr), 32'(mon_e.addr));
            if (mon_e.chk_idx) check($sformatf("note_idx@%0d", cyc), 32'(note_idx), 32'(mon_e.idx));
        end
    end

    function automatic ent_t mk(input logic en, input logic [31:0] per, input logic b,
                                input logic d, input int addr);
        ent_t e;
        e.en = en; e.per = per; e.busy = b; e.done = d;
        e.idx = '0; e.chk_idx = 1'b0; e.addr = ADDR_W'(addr);
        e.is_play = 1'b0; e.p = 1'b0; e.sb = 1'b0; e.sp = 1'b0;
        return e;
    endfunction

    // Song playback from the rules: 2 fetch cycles, duration*BC play cycles per note.
    function automatic void build_song();
        logic        pe = 1'b0;
        logic [31:0] pp = '0;
        int          a  = 0;
        int          dur;
        logic [31:0] per;
        ent_t        e;
        tl.delete();
        forever begin
            tl.push_back(mk(pe && !GAP_ON, pp, 1'b1, 1'b0, a));
            tl.push_back(mk(pe && !GAP_ON, pp, 1'b1, 1'b0, a));
            dur = int'(rom_mem[a][39:32]);
            per = rom_mem[a][31:0];
            if (dur == 0) break;
            for (int k = 0; k < dur * BC; k++) begin
                e = mk(per != 0, per, 1'b1, 1'b0, a);
                if (GAP_ON && (k / BC == dur - 1) && (k % BC >= BC - GC)) e.en = 1'b0;
                e.idx = ADDR_W'(a); e.chk_idx = 1'b1; e.is_play = 1'b1;
                tl.push_back(e);
            end
            pe = (per != 0);
            pp = per;
            if (a == DEPTH - 1) break;
            a++;
        end
        tl.push_back(mk(pe && !GAP_ON, pp, 1'b1, 1'b1, a));
        for (int i = 0; i < 3; i++) tl.push_back(mk(1'b0, '0, 1'b0, 1'b0, a));
    endfunction

    // Pause for k cycles starting at play entry j; optionally also held over the preceding fetch.
    function automatic void add_pause(input int j, input int k, input bit back);
        ent_t fr;
        fr = tl[j];
        fr.en = 1'b0;
        fr.p  = 1'b1;
        for (int m = 0; m < k; m++) tl.insert(j, fr);
        if (back) begin
            for (int i = j - 1; i >= 0; i--) begin
                if (tl[i].is_play || !tl[i].busy || tl[i].done) break;
                tl[i].p = 1'b1;
            end
        end
    endfunction

    function automatic void add_stop(input int s);
        while (tl.size() > s + 1) void'(tl.pop_back());
        tl[s].sp = 1'b1;
        for (int i = 0; i < 3; i++) tl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 0));
    endfunction

    function automatic void add_busy_starts(input int every);
        foreach (tl[i]) if (tl[i].busy && (i % every == 1)) tl[i].sb = 1'b1;
    endfunction

    function automatic int rand_play_entry();
        int plays[$];
        foreach (tl[i]) if (tl[i].is_play) plays.push_back(i);
        return plays[$urandom_range(0, plays.size() - 1)];
    endfunction

    function automatic int first_idle();
        foreach (tl[i]) if (!tl[i].busy) return i;
        return tl.size();
    endfunction

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic drive_song();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (tl[i]) exp_q.push_back(tl[i]);
        for (int j = 0; j < tl.size(); j++) begin
            pause = tl[j].p;
            start = tl[j].sb;
            stop  = tl[j].sp;
            @(posedge clk); #1;
        end
        pause = 1'b0; start = 1'b0; stop = 1'b0;
        drain();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wave_en"}, 32'(wave_en), 0);
        check({tag, "_wave_period"}, wave_period, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_note_idx"}, 32'(note_idx), 0);
        check({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    endtask

    task automatic load_basic();
        foreach (rom_mem[i]) rom_mem[i] = '0;
        rom_mem[0] = {8'd2, 32'd1000};
        rom_mem[1] = {8'd1, 32'd2000};
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        foreach (rom_mem[i]) rom_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        load_basic();
        build_song();
        drive_song();

        foreach (rom_mem[i]) rom_mem[i] = '0;
        rom_mem[0] = {8'd1, 32'd1500};
        rom_mem[1] = {8'd1, 32'd0};
        rom_mem[2] = {8'd2, 32'd3000};
        build_song();
        drive_song();

        load_basic();
        build_song();
        add_pause(5, 5, 1'b0);
        drive_song();

        load_basic();
        build_song();
        add_pause(2 + 2 * BC + 2, 3, 1'b1);
        drive_song();

        load_basic();
        build_song();
        add_stop(5);
        drive_song();

        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 0));
        drain();

        foreach (rom_mem[i]) rom_mem[i] = {8'd1, 32'(100 * (i + 1))};
        build_song();
        add_busy_starts(3);
        drive_song();

        foreach (rom_mem[i]) rom_mem[i] = '0;
        rom_mem[0] = {8'd1, 32'd1000};
        rom_mem[1] = {8'd1, 32'd1000};
        build_song();
        drive_song();

        load_basic();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_values("rst_mid_note");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            foreach (rom_mem[i]) begin
                if (i < n)
                    rom_mem[i] = {8'($urandom_range(1, 3)),
                                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom()};
                else
                    rom_mem[i] = {8'd0, $urandom()};
            end
            build_song();
            if ($urandom_range(0, 1) == 1)
                add_pause(rand_play_entry(), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 3) add_stop($urandom_range(0, first_idle() - 1));
            if ($urandom_range(0, 1) == 1) add_busy_starts($urandom_range(2, 7));
            drive_song();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
